// File: rtl/hazard_forward_unit.sv
// Pipeline hazard unit: EX operand forwarding, load-use stall FSM and redirect flush.
// Define HAZARD_PERF_COUNTERS_EN to build the stall_cycles/flush_count performance counters.
module hazard_forward_unit #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int FWD_STAGES = 2,
  parameter int LOAD_LAT   = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [ADDR_W-1:0]            id_rs_addr,
  input  logic [ADDR_W-1:0]            id_rt_addr,
  input  logic                         id_uses_rs,
  input  logic                         id_uses_rt,
  input  logic                         ex_is_load,
  input  logic [ADDR_W-1:0]            ex_wr_addr,
  input  logic [ADDR_W-1:0]            ex_rs_addr,
  input  logic [ADDR_W-1:0]            ex_rt_addr,
  input  logic [DATA_W-1:0]            ex_rs_data,
  input  logic [DATA_W-1:0]            ex_rt_data,
  input  logic [FWD_STAGES-1:0]        fwd_regwrite,
  input  logic [FWD_STAGES*ADDR_W-1:0] fwd_addr,
  input  logic [FWD_STAGES*DATA_W-1:0] fwd_data,
  input  logic                         redirect,
  output logic [DATA_W-1:0]            op_a,
  output logic [DATA_W-1:0]            op_b,
  output logic                         pc_en,
  output logic                         ifid_en,
  output logic                         ifid_flush,
  output logic                         idex_bubble,
  output logic [15:0]                  stall_cycles,
  output logic [15:0]                  flush_count,
  output logic                         dbgState
);

  localparam int CNT_W = $clog2(LOAD_LAT + 1);

  typedef enum logic {RUN, STALL} state_t;

  state_t           state, nextState;
  logic [CNT_W-1:0] cnt, nextCnt;
  logic             loadUse;

  // Walk from oldest to youngest so the lowest matching stage wins.
  always_comb begin
    op_a = ex_rs_data;
    op_b = ex_rt_data;
    for (int i = FWD_STAGES - 1; i >= 0; i--) begin
      if (fwd_regwrite[i] && fwd_addr[i*ADDR_W +: ADDR_W] == ex_rs_addr && ex_rs_addr != '0)
        op_a = fwd_data[i*DATA_W +: DATA_W];
      if (fwd_regwrite[i] && fwd_addr[i*ADDR_W +: ADDR_W] == ex_rt_addr && ex_rt_addr != '0)
        op_b = fwd_data[i*DATA_W +: DATA_W];
    end
  end

  assign loadUse = ex_is_load && ex_wr_addr != '0 &&
                   ((id_uses_rs && id_rs_addr == ex_wr_addr) ||
                    (id_uses_rt && id_rt_addr == ex_wr_addr));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= nextState;
      cnt   <= nextCnt;
    end
  end

  always_comb begin
    nextState   = state;
    nextCnt     = cnt;
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (redirect) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      nextState   = RUN;
      nextCnt     = '0;
    end else begin
      case (state)
        RUN: begin
          if (loadUse) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_bubble = 1'b1;
            if (LOAD_LAT > 1) begin
              nextState = STALL;
              nextCnt   = CNT_W'(LOAD_LAT - 1);
            end
          end
        end
        STALL: begin
          pc_en       = 1'b0;
          ifid_en     = 1'b0;
          idex_bubble = 1'b1;
          if (cnt <= CNT_W'(1)) begin
            nextState = RUN;
            nextCnt   = '0;
          end else begin
            nextCnt = cnt - CNT_W'(1);
          end
        end
        default: begin
          nextState = RUN;
          nextCnt   = '0;
        end
      endcase
    end
    // While reset is held the pipeline free-runs regardless of hazard inputs.
    if (!reset) begin
      pc_en       = 1'b1;
      ifid_en     = 1'b1;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
    end
  end

  assign dbgState = (state == STALL);

`ifdef HAZARD_PERF_COUNTERS_EN
  logic        stallBubble;
  logic [15:0] stallCnt, flushCnt;

  // A bubble without redirect can only come from a load-use stall.
  assign stallBubble = idex_bubble && !redirect;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stallCnt <= '0;
      flushCnt <= '0;
    end else begin
      if (stallBubble && stallCnt != 16'hFFFF) stallCnt <= stallCnt + 16'd1;
      if (redirect && flushCnt != 16'hFFFF)    flushCnt <= flushCnt + 16'd1;
    end
  end

  assign stall_cycles = stallCnt;
  assign flush_count  = flushCnt;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Scoreboard bench for hazard_forward_unit: two instances (LOAD_LAT 1 and 3) share random
// and directed stimulus and are compared each cycle against a behavioural model.
module tb_hazard_forward_unit;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int FS = 2;
  localparam int EW = 2*DW + 4 + 32;
`ifdef HAZARD_PERF_COUNTERS_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic [AW-1:0] id_rs_addr, id_rt_addr, ex_wr_addr, ex_rs_addr, ex_rt_addr;
  logic          id_uses_rs, id_uses_rt, ex_is_load, redirect;
  logic [DW-1:0] ex_rs_data, ex_rt_data;
  logic [FS-1:0]    fwd_regwrite;
  logic [FS*AW-1:0] fwd_addr;
  logic [FS*DW-1:0] fwd_data;

  logic [DW-1:0] a1, b1, a3, b3;
  logic          pc1, ie1, fl1, bu1, st1, pc3, ie3, fl3, bu3, st3;
  logic [15:0]   sc1, fc1, sc3, fc3;

  logic [EW-1:0] exp_q1[$];
  logic [EW-1:0] exp_q3[$];
  int checks = 0;
  int errors = 0;

  int remain[2];
  int sc[2];
  int fc[2];
  int latOf[2] = '{1, 3};

  hazard_forward_unit #(.DATA_W(DW), .ADDR_W(AW), .FWD_STAGES(FS), .LOAD_LAT(1)) u1 (
    .clk(clk), .reset(reset),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_is_load(ex_is_load), .ex_wr_addr(ex_wr_addr), .ex_rs_addr(ex_rs_addr), .ex_rt_addr(ex_rt_addr),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
    .fwd_regwrite(fwd_regwrite), .fwd_addr(fwd_addr), .fwd_data(fwd_data), .redirect(redirect),
    .op_a(a1), .op_b(b1), .pc_en(pc1), .ifid_en(ie1), .ifid_flush(fl1), .idex_bubble(bu1),
    .stall_cycles(sc1), .flush_count(fc1), .dbgState(st1)
  );

  hazard_forward_unit #(.DATA_W(DW), .ADDR_W(AW), .FWD_STAGES(FS), .LOAD_LAT(3)) u3 (
    .clk(clk), .reset(reset),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_is_load(ex_is_load), .ex_wr_addr(ex_wr_addr), .ex_rs_addr(ex_rs_addr), .ex_rt_addr(ex_rt_addr),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
    .fwd_regwrite(fwd_regwrite), .fwd_addr(fwd_addr), .fwd_data(fwd_data), .redirect(redirect),
    .op_a(a3), .op_b(b3), .pc_en(pc3), .ifid_en(ie3), .ifid_flush(fl3), .idex_bubble(bu3),
    .stall_cycles(sc3), .flush_count(fc3), .dbgState(st3)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference model: forwarding picks the youngest matching producer; a load-use hazard
  // costs latOf[k] bubble cycles, redirect cancels any pending stall.
  function automatic logic [DW-1:0] fwd_pick(input logic [AW-1:0] addr, input logic [DW-1:0] rf);
    logic [DW-1:0] v;
    bit found;
    v = rf;
    found = 0;
    for (int i = 0; i < FS; i++) begin
      if (!found && addr != 0 && fwd_regwrite[i] && fwd_addr[i*AW +: AW] == addr) begin
        v = fwd_data[i*DW +: DW];
        found = 1;
      end
    end
    return v;
  endfunction

  task automatic model(input int k, output logic [EW-1:0] e);
    logic pc, ie, fl, bu;
    int scOut, fcOut;
    bit haz;
    haz = ex_is_load && ex_wr_addr != 0 &&
          ((id_uses_rs && id_rs_addr == ex_wr_addr) || (id_uses_rt && id_rt_addr == ex_wr_addr));
    pc = 1; ie = 1; fl = 0; bu = 0;
    if (!reset) begin
      remain[k] = 0; sc[k] = 0; fc[k] = 0;
      scOut = 0; fcOut = 0;
    end else begin
      scOut = PERF ? sc[k] : 0;
      fcOut = PERF ? fc[k] : 0;
      if (redirect) begin
        fl = 1; bu = 1;
        remain[k] = 0;
        if (fc[k] < 65535) fc[k]++;
      end else if (remain[k] > 0 || haz) begin
        pc = 0; ie = 0; bu = 1;
        if (remain[k] > 0) remain[k]--;
        else remain[k] = latOf[k] - 1;
        if (sc[k] < 65535) sc[k]++;
      end
    end
    e = {fwd_pick(ex_rs_addr, ex_rs_data), fwd_pick(ex_rt_addr, ex_rt_data),
         pc, ie, fl, bu, 16'(scOut), 16'(fcOut)};
  endtask

  // Driver tasks
  task automatic step();
    logic [EW-1:0] e;
    model(0, e); exp_q1.push_back(e);
    model(1, e); exp_q3.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset = 1; redirect = 0; ex_is_load = 0; ex_wr_addr = 0;
    id_uses_rs = 0; id_uses_rt = 0; id_rs_addr = 0; id_rt_addr = 0;
    ex_rs_addr = 0; ex_rt_addr = 0; ex_rs_data = 32'h1111_0000; ex_rt_data = 32'h2222_0000;
    fwd_regwrite = 0; fwd_addr = 0; fwd_data = 0;
  endtask

  task automatic load_hazard();
    ex_is_load = 1; ex_wr_addr = 5'd8; id_uses_rt = 1; id_rt_addr = 5'd8;
  endtask

  task automatic randomize_inputs();
    reset = ($urandom_range(0, 99) != 0);
    redirect = ($urandom_range(0, 19) == 0);
    ex_is_load = ($urandom_range(0, 2) == 0);
    ex_wr_addr = AW'($urandom_range(0, 7));
    id_rs_addr = AW'($urandom_range(0, 7));
    id_rt_addr = AW'($urandom_range(0, 7));
    id_uses_rs = 1'($urandom_range(0, 1));
    id_uses_rt = 1'($urandom_range(0, 1));
    ex_rs_addr = AW'($urandom_range(0, 7));
    ex_rt_addr = AW'($urandom_range(0, 7));
    ex_rs_data = $urandom;
    ex_rt_data = $urandom;
    fwd_regwrite = FS'($urandom_range(0, 3));
    for (int i = 0; i < FS; i++) begin
      fwd_addr[i*AW +: AW] = AW'($urandom_range(0, 7));
      fwd_data[i*DW +: DW] = $urandom;
    end
  endtask

  // Scoreboard
  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic cmp_all(input string inst, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    cmp({inst, ".op_a"},         act[99:68], exp[99:68]);
    cmp({inst, ".op_b"},         act[67:36], exp[67:36]);
    cmp({inst, ".pc_en"},        32'(act[35]), 32'(exp[35]));
    cmp({inst, ".ifid_en"},      32'(act[34]), 32'(exp[34]));
    cmp({inst, ".ifid_flush"},   32'(act[33]), 32'(exp[33]));
    cmp({inst, ".idex_bubble"},  32'(act[32]), 32'(exp[32]));
    cmp({inst, ".stall_cycles"}, 32'(act[31:16]), 32'(exp[31:16]));
    cmp({inst, ".flush_count"},  32'(act[15:0]), 32'(exp[15:0]));
  endtask

  always @(negedge clk) begin
    if (exp_q1.size() > 0) cmp_all("lat1", {a1, b1, pc1, ie1, fl1, bu1, sc1, fc1}, exp_q1.pop_front());
    if (exp_q3.size() > 0) cmp_all("lat3", {a3, b3, pc3, ie3, fl3, bu3, sc3, fc3}, exp_q3.pop_front());
  end

  // Stimulus
  initial begin
    idle();
    reset = 0;
    @(posedge clk);
    #1;
    step(); step();
    idle();
    step();

    // Stage 0 wins over stage 1 on the same address
    fwd_regwrite = 2'b11; fwd_addr = {5'd5, 5'd5}; fwd_data = {32'h22, 32'h11};
    ex_rs_addr = 5'd5; ex_rs_data = 32'h99;
    step();
    // Register 0 is never forwarded
    idle();
    ex_rt_addr = 0; fwd_regwrite = 2'b01; fwd_addr = 0; fwd_data = {32'h0, 32'hDEAD}; ex_rt_data = 32'h7;
    step();

    // Single-cycle load-use hazard, then drain
    idle(); load_hazard(); step();
    idle(); repeat (4) step();

    // Redirect in the second stall cycle of the long-latency instance
    load_hazard(); step();
    idle(); redirect = 1; step();
    idle(); repeat (3) step();

    // Hazard together with redirect must not stall; r0 destination is no hazard
    load_hazard(); redirect = 1; step();
    idle(); load_hazard(); ex_wr_addr = 0; id_rt_addr = 0; step();
    idle(); step();

    // Reset in the middle of a stall
    load_hazard(); step();
    idle(); step();
    reset = 0; step();
    idle(); repeat (3) step();

    // Hazard held continuously
    load_hazard(); repeat (8) step();
    idle(); repeat (3) step();

    // 100 separated hazards
    for (int n = 0; n < 100; n++) begin
      idle(); load_hazard(); step();
      idle(); repeat (3) step();
    end

    for (int n = 0; n < 3000; n++) begin
      randomize_inputs();
      step();
    end

    idle(); repeat (4) step();
    for (int w = 0; w < 10 && (exp_q1.size() > 0 || exp_q3.size() > 0); w++) @(posedge clk);
    checks++;
    if (exp_q1.size() != 0 || exp_q3.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d/%0d expectations left, expected 0", exp_q1.size(), exp_q3.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
